// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and helpers for the instruction-fetch front end.
//   INST_W / PC_W / ENTRY_W : instruction, PC and queue-entry widths
//   PC_STEP                 : byte distance between consecutive instruction words
//   RESET_PC_DEFAULT        : default fetch PC after reset
//   sext16 / sext26         : sign-extend branch / jump byte offsets to 32 bits
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam int          PC_W             = 32;
  localparam int          ENTRY_W          = PC_W + INST_W;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sext26(input logic [25:0] v);
    return {{6{v[25]}}, v};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x 64-bit synchronous FIFO holding {pc, instruction} pairs.
//   clk, reset   : clock and synchronous active-high reset
//   flush        : empty the queue; push and pop are ignored that cycle
//   push         : write push_data at the tail
//   push_data    : {pc, instruction}
//   pop          : remove the head (ignored when empty)
//   head_data    : current head entry
//   full, empty  : registered occupancy flags
//   count        : registered occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic [ENTRY_W-1:0]             push_data,
  input  logic                           pop,
  output logic [ENTRY_W-1:0]             head_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic               empty_r;
  logic               full_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Effective push/pop strobes and next occupancy; flush overrides both.
  always_comb begin
    do_push_s   = push & ~flush;
    do_pop_s    = pop & ~empty_r & ~flush;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = CNT_ZERO;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Storage, pointers and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CNT_ZERO);
      full_r  <= (count_nxt_s == DEPTH_C);
      if (flush) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (do_push_s) begin
          mem_r[wr_ptr_r] <= push_data;
          wr_ptr_r        <= wr_ptr_r + PTR_ONE;
        end
        if (do_pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;

  fetch_fifo_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (do_push_s),
    .pop   (do_pop_s),
    .full  (full_r)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// fetch_fifo_chk: assertion-only companion of fetch_fifo.
//   clk, reset       : clock and synchronous active-high reset
//   flush            : queue is being emptied this cycle
//   push, pop        : effective push / pop strobes
//   full             : registered full flag
module fetch_fifo_chk (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic push,
  input logic pop,
  input logic full
);

  // A push into a full queue without a simultaneous pop would lose an entry.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end with prefetch queue.
//   clk, reset                      : clock, synchronous active-high reset
//   fetch_en                        : allow new memory requests
//   imem_req_valid/ready/addr       : in-order word requests to instruction memory
//   imem_resp_valid/data            : in-order responses from instruction memory
//   out_valid/ready, out_inst/pc    : queue head presented to decode
//   ctrl_pc, branch, jmp, jmp_r     : redirect request from decode (jmp_r > branch > jmp)
//   imm16, jmp_imm26, reg_imm32     : redirect offsets / register target
// A redirect flushes the queue; responses owed to requests issued before it
// are counted in drop_r and discarded as they arrive.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic [31:0] ctrl_pc,
  input  logic        branch,
  input  logic        jmp,
  input  logic        jmp_r,
  input  logic [15:0] imm16,
  input  logic [25:0] jmp_imm26,
  input  logic [31:0] reg_imm32
);

  localparam int               CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  logic [31:0]        fetch_pc_r;
  logic [31:0]        pc_tag_r;
  logic [CNT_W-1:0]   inflight_r;
  logic [CNT_W-1:0]   inflight_nxt_s;
  logic [CNT_W-1:0]   drop_r;
  logic [CNT_W-1:0]   drop_nxt_s;
  logic [31:0]        target_s;
  logic               redirect_s;
  logic [CNT_W:0]     occ_sum_s;
  logic               req_valid_s;
  logic               req_fire_s;
  logic               resp_drop_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] head_s;

  // Redirect target selection, 32-bit wrap-around, offsets are byte offsets.
  always_comb begin
    target_s = reg_imm32;
    if (jmp_r) begin
      target_s = reg_imm32;
    end else if (branch) begin
      target_s = ctrl_pc + PC_STEP + sext16(imm16);
    end else begin
      target_s = ctrl_pc + PC_STEP + sext26(jmp_imm26);
    end
  end

  // Request credit check, response steering and queue strobes.
  always_comb begin
    redirect_s  = branch | jmp | jmp_r;
    // Every buffered or outstanding fetch owns a queue slot, so pushes never overflow.
    occ_sum_s   = {1'b0, fifo_count_s} + {1'b0, inflight_r};
    // Full already implies no credit; the direct guard keeps the flag meaningful.
    req_valid_s = fetch_en & ~redirect_s & ~reset & ~fifo_full_s & (occ_sum_s < CREDIT_MAX);
    req_fire_s  = req_valid_s & imem_req_ready;
    resp_drop_s = imem_resp_valid & (drop_r != CNT_ZERO);
    push_s      = imem_resp_valid & ~resp_drop_s & ~redirect_s;
    pop_s       = ~fifo_empty_s & out_ready & ~redirect_s;
  end

  // Outstanding-request and squash counters.
  always_comb begin
    case ({req_fire_s, imem_resp_valid})
      2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
      2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
      default: inflight_nxt_s = inflight_r;
    endcase
    // On a redirect every request still unanswered after this cycle is stale.
    if (redirect_s) begin
      drop_nxt_s = inflight_nxt_s;
    end else if (resp_drop_s) begin
      drop_nxt_s = drop_r - CNT_ONE;
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // Fetch PC, response PC tag and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      pc_tag_r   <= RESET_PC;
      inflight_r <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
    end else begin
      inflight_r <= inflight_nxt_s;
      drop_r     <= drop_nxt_s;
      if (redirect_s) begin
        fetch_pc_r <= target_s;
        pc_tag_r   <= target_s;
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        // The tag tracks the PC of the next response that will be kept.
        if (push_s) begin
          pc_tag_r <= pc_tag_r + PC_STEP;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_s),
    .push      (push_s),
    .push_data ({pc_tag_r, imem_resp_data}),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign out_valid      = ~fifo_empty_s;
  assign out_pc         = head_s[ENTRY_W-1:INST_W];
  assign out_inst       = head_s[INST_W-1:0];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: a table of per-cycle vectors for
// streaming/backpressure, then hand-written redirect, squash, priority and
// mid-stream reset sequences. Instruction memory is modelled with a fixed
// latency; each word's data is derived from its address.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] ctrl_pc;
  logic        branch;
  logic        jmp;
  logic        jmp_r;
  logic [15:0] imm16;
  logic [25:0] jmp_imm26;
  logic [31:0] reg_imm32;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .ctrl_pc         (ctrl_pc),
    .branch          (branch),
    .jmp             (jmp),
    .jmp_r           (jmp_r),
    .imm16           (imm16),
    .jmp_imm26       (jmp_imm26),
    .reg_imm32       (reg_imm32)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        fe;
    logic        ordy;
    logic        rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t mq[$];
  vec_t  tbl [26];
  int    cyc   = 0;
  int    lat   = 1;
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Start of a cycle: inputs change only here, away from the rising edge.
  task automatic begin_cycle();
    @(negedge clk);
    reset  = 1'b0;
    branch = 1'b0;
    jmp    = 1'b0;
    jmp_r  = 1'b0;
  endtask

  // Present the due memory response, let logic settle, record an accepted request.
  task automatic settle();
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
      mq.push_back('{imem_req_addr, cyc + lat});
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    mq.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset  = 1'b1;
      branch = 1'b0;
      jmp    = 1'b0;
      jmp_r  = 1'b0;
      settle();
      check_bit("rst_req_valid", imem_req_valid, 1'b0);
      if (i > 0) begin
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_word("rst_out_inst", out_inst, 32'h0);
        check_word("rst_out_pc", out_pc, 32'h0);
      end
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      begin_cycle();
      settle();
      if (out_valid === 1'b1) return;
    end
    check_bit({name, "_timeout"}, out_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; ctrl_pc = 32'h0;
    branch = 1'b0; jmp = 1'b0; jmp_r = 1'b0;
    imm16 = 16'h0; jmp_imm26 = 26'h0; reg_imm32 = 32'h0;

    //            fe    ordy  rdy   rv    addr      ov    pc
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 1'b1, 32'h24};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h34, 1'b1, 32'h28};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h2C};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h30};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h34};
    tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h38, 1'b0, 32'h00};
    tbl[23] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h38, 1'b0, 32'h00};
    tbl[24] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h3C, 1'b0, 32'h00};
    tbl[25] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h38};

    // Streaming, decode backpressure, fetch_en and memory-ready stalls.
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 26; i++) begin
      begin_cycle();
      fetch_en       = tbl[i].fe;
      out_ready      = tbl[i].ordy;
      imem_req_ready = tbl[i].rdy;
      settle();
      check_bit($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) check_word($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      check_bit($sformatf("v%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      if (tbl[i].exp_ov) begin
        check_word($sformatf("v%0d_out_pc", i), out_pc, tbl[i].exp_pc);
        check_word($sformatf("v%0d_out_inst", i), out_inst, inst_of(tbl[i].exp_pc));
      end
    end

    // Branch redirect with a negative offset: 0x20 + 4 - 8 = 0x1C.
    lat = 1; fetch_en = 1'b1; out_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset(2);
    repeat (4) begin begin_cycle(); settle(); end
    begin_cycle(); branch = 1'b1; ctrl_pc = 32'h20; imm16 = 16'hFFF8; settle();
    check_bit("br_req_blocked", imem_req_valid, 1'b0);
    begin_cycle(); settle();
    check_bit("br_flushed", out_valid, 1'b0);
    check_bit("br_req_valid", imem_req_valid, 1'b1);
    check_word("br_req_addr", imem_req_addr, 32'h1C);
    wait_valid(8, "br");
    check_word("br_first_pc", out_pc, 32'h1C);
    check_word("br_first_inst", out_inst, inst_of(32'h1C));
    begin_cycle(); settle();
    check_word("br_second_pc", out_pc, 32'h20);

    // Squash: 3-cycle memory, jmp with two requests in flight; 0x100 + 4 - 16 = 0xF4.
    lat = 3;
    do_reset(2);
    begin_cycle(); settle();
    begin_cycle(); settle();
    begin_cycle(); jmp = 1'b1; ctrl_pc = 32'h100; jmp_imm26 = 26'h3FF_FFF0; settle();
    check_bit("sq_req_blocked", imem_req_valid, 1'b0);
    begin_cycle(); settle();
    check_bit("sq_flushed", out_valid, 1'b0);
    check_word("sq_req_addr", imem_req_addr, 32'hF4);
    wait_valid(12, "sq");
    check_word("sq_first_pc", out_pc, 32'hF4);
    check_word("sq_first_inst", out_inst, inst_of(32'hF4));
    begin_cycle(); settle();
    check_word("sq_second_pc", out_pc, 32'hF8);
    check_word("sq_second_inst", out_inst, inst_of(32'hF8));

    // Priority jmp_r > branch > jmp, with a second redirect while responses are still owed.
    lat = 3;
    do_reset(2);
    begin_cycle(); settle();
    begin_cycle(); settle();
    begin_cycle();
    branch = 1'b1; jmp = 1'b1; jmp_r = 1'b1; reg_imm32 = 32'h400;
    ctrl_pc = 32'h20; imm16 = 16'h0010; jmp_imm26 = 26'h100;
    settle();
    begin_cycle(); settle();
    check_word("pri_jr_addr", imem_req_addr, 32'h400);
    begin_cycle();
    branch = 1'b1; jmp = 1'b1; ctrl_pc = 32'h40; imm16 = 16'h0010; jmp_imm26 = 26'h100;
    settle();
    begin_cycle(); settle();
    check_word("pri_br_addr", imem_req_addr, 32'h54);
    wait_valid(12, "pri");
    check_word("pri_first_pc", out_pc, 32'h54);
    check_word("pri_first_inst", out_inst, inst_of(32'h54));

    // Reset mid-stream with three buffered entries.
    lat = 1; out_ready = 1'b0; fetch_en = 1'b1;
    do_reset(2);
    begin_cycle(); settle();
    begin_cycle(); settle();
    begin_cycle(); settle();
    begin_cycle(); fetch_en = 1'b0; settle();
    begin_cycle(); settle();
    check_bit("mr_held_valid", out_valid, 1'b1);
    check_word("mr_held_pc", out_pc, 32'h0);
    check_bit("mr_no_req", imem_req_valid, 1'b0);
    begin_cycle(); reset = 1'b1; fetch_en = 1'b1; mq.delete(); settle();
    check_bit("mr_rst_req", imem_req_valid, 1'b0);
    begin_cycle(); settle();
    check_bit("mr_out_valid", out_valid, 1'b0);
    check_word("mr_out_inst", out_inst, 32'h0);
    check_word("mr_out_pc", out_pc, 32'h0);
    check_bit("mr_req_valid", imem_req_valid, 1'b1);
    check_word("mr_req_addr", imem_req_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end with decoupled memory and decode handshakes. Holds the fetch PC, issues in-order word requests to instruction memory, buffers up to DEPTH returned instructions, each tagged with its PC, in a FIFO, and presents them to decode via valid/ready. Control-flow redirects from decode (branch, jump, jump-register) flush the queue and discard in-flight responses. Sits between instruction memory and the decode stage, and adds prefetch, stall and flush behaviour.

## Interface
- DEPTH, 4, queue entries and max outstanding-plus-buffered fetches; power of 2, ≥2
- RESET_PC, 32'h0000_0000, fetch PC after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- fetch_en  in  1  0 = issue no new requests (in-flight ones still complete)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address (byte-addressed, multiple of 4)
- imem_resp_valid  in  1  response data valid (in order, ≥1 cycle after accept)
- imem_resp_data  in  32  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode consumes head
- out_inst  out  32  head instruction
- out_pc  out  32  head PC
- ctrl_pc  in  32  PC of the instruction that requests the redirect
- branch, jmp, jmp_r  in  1 each  redirect requests (taken)
- imm16  in  16  branch byte offset
- jmp_imm26  in  26  jump byte offset
- reg_imm32  in  32  register-file target for jmp_r

## Operation
- Redirect = branch|jmp|jmp_r. Priority: jmp_r > branch > jmp.
- Targets use 32-bit wrap-around arithmetic. Offsets are not shifted.
  - jmp_r → reg_imm32
  - branch → ctrl_pc+4+sext(imm16)
  - jmp → ctrl_pc+4+sext(jmp_imm26)
- Counters:
  - count = queue occupancy.
  - inflight = accepted requests not yet answered.
  - drop = responses still owed to squashed requests.
  - Widths are clog2(DEPTH+1).
- Request rule: imem_req_valid = fetch_en & ~redirect & ~reset & (count+inflight < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept, fetch_pc += 4 (wraps at 2^32).
- Response handling:
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise {fetch PC of that request, data} is pushed into the queue.
  - The pushed PC comes from an internal pc-tag counter advanced per accepted response.
- Pop when out_valid & out_ready. Push and pop may occur together at any occupancy. The credit rule makes overflow impossible, and a push into a full queue is an assertion failure.
- Redirect cycle:
  - fetch_pc ← target; the pc-tag counter ← target.
  - Queue emptied; any pop or push that cycle is ignored.
  - drop ← inflight after this cycle's response (an arriving response that cycle is discarded); inflight unchanged.
- Successive redirects accumulate into drop correctly: responses owed = inflight.
- Reset values: fetch_pc = RESET_PC; count, inflight and drop = 0; out_valid = 0; imem_req_valid = 0; out_inst and out_pc = 0.
- Reset mid-operation: all state is cleared. Responses arriving afterwards for pre-reset requests are a memory-side violation and are not handled.

## Timing
- Response-to-output latency: a response pushed in cycle N makes out_valid=1 in cycle N+1, with data registered.
- Redirect latency: redirect in cycle N → out_valid=0 in N+1 → first request to target in N+1 → target instruction visible no earlier than N+1+mem latency+1.
- Request after reset: imem_req_valid may rise in the first cycle after reset deasserts.
- Sustained throughput is 1 instruction/cycle when memory latency ≤ DEPTH−1 and out_ready is held high.
- out_valid, out_inst and out_pc are held stable while out_valid & ~out_ready, unless a redirect or reset occurs.

## Structure
- Shared package `fetch_pkg`:
  - INST_W = 32
  - PC_STEP = 4
  - RESET_PC default
  - sext16 and sext26 helper functions
- Sub-module `fetch_fifo`: a DEPTH×64 synchronous FIFO with flush, push, pop, full, empty and count.
- Target computation, counters and request logic live in the top module.

## Test plan
- Basic stream: reset, 1-cycle memory, fetch_en=1, out_ready=1 → out_pc = 0,4,8,12… on consecutive cycles; out_inst matches memory.
- Backpressure: out_ready=0 → exactly DEPTH(4) requests accepted, then imem_req_valid=0. Raising out_ready resumes fetch without loss or duplication.
- Branch redirect: ctrl_pc=0x20, branch=1, imm16=16'hFFF8 → next request addr 0x1C; first out_pc after the flush is 0x1C.
- Squash: 3-cycle memory latency, jmp issued with 2 requests in flight → both responses discarded; first output is ctrl_pc+4+sext(jmp_imm26).
- Priority: branch=jmp=jmp_r=1, reg_imm32=0x400 → next request addr 0x400.
- Reset mid-stream: queue holds 3 entries, reset pulses 1 cycle → out_valid=0, and the next request addr is RESET_PC.
